multicycle_ctrl_unit: RTL and testbench

Parametrised successor to the RV32I multicycle decode/control FSM. It decodes the held instruction register and sequences the multicycle datapath through fetch, decode, execute, memory and writeback. Relative to the previous block it adds:
- a memory ready handshake with wait states,
- full RV32I opcode coverage (LUI, AUIPC, JAL, JALR, branches, loads and stores),
- illegal-instruction trapping,
- a retired-instruction counter.

---
 rtl/multicycle_ctrl_unit.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_unit.sv
// RV32I multicycle decode/control FSM: decodes the held instruction register and sequences
// fetch/decode/execute/memory/writeback with memory wait states, trapping and retire counting.
module multicycle_ctrl_unit #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned INSTRET_W     = 32,
  parameter bit          MEM_HANDSHAKE = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          instruction_reg,
  input  logic                 Cond_Chk_reg,
  input  logic                 mem_ready,
  output logic [6:0]           opcode_reg,
  output logic [4:0]           rs1_reg,
  output logic [4:0]           rs2_reg,
  output logic [4:0]           rd_reg,
  output logic [2:0]           funct3_reg,
  output logic [6:0]           funct7_reg,
  output logic [XLEN-1:0]      Imm_reg,
  output logic                 IorD_reg,
  output logic                 MemWrite_reg,
  output logic                 IRWrite_reg,
  output logic                 AluSrcA_reg,
  output logic                 PCSrc_reg,
  output logic                 RegWrite_reg,
  output logic                 Branch_reg,
  output logic                 PCWrite_reg,
  output logic                 PCEn_reg,
  output logic [1:0]           MtoR_reg,
  output logic [1:0]           AluSrcB_reg,
  output logic [3:0]           AluControl_reg,
  output logic                 mem_req,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret,
  output logic [4:0]           current_stage,
  output logic [4:0]           next_stage
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam logic [3:0] AluAdd   = 4'd0;
  localparam logic [3:0] AluSub   = 4'd1;
  localparam logic [3:0] AluSll   = 4'd2;
  localparam logic [3:0] AluSlt   = 4'd3;
  localparam logic [3:0] AluSltu  = 4'd4;
  localparam logic [3:0] AluXor   = 4'd5;
  localparam logic [3:0] AluSrl   = 4'd6;
  localparam logic [3:0] AluSra   = 4'd7;
  localparam logic [3:0] AluOr    = 4'd8;
  localparam logic [3:0] AluAnd   = 4'd9;
  localparam logic [3:0] AluPassB = 4'd10;

  typedef enum logic [4:0] {
    StFetch  = 5'd0,
    StDecode = 5'd1,
    StMemAdr = 5'd2,
    StMemRd  = 5'd3,
    StMemWb  = 5'd4,
    StMemWr  = 5'd5,
    StExecR  = 5'd6,
    StExecI  = 5'd7,
    StAluWb  = 5'd8,
    StBranch = 5'd9,
    StJal    = 5'd10,
    StJalr   = 5'd11,
    StLui    = 5'd12,
    StAuipc  = 5'd13,
    StTrap   = 5'd31
  } state_e;

  state_e                 state_q, state_d;
  logic                   illegal_q, illegal_d;
  logic [INSTRET_W-1:0]   instret_q, instret_d;
  logic                   retire;
  logic                   rdy;
  logic                   op_funct7_ok;
  logic signed [31:0]     imm32;
  logic [3:0]             alu_rtype;
  logic [3:0]             alu_itype;
  logic [3:0]             alu_branch;

  assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

  assign opcode_reg = instruction_reg[6:0];
  assign rd_reg     = instruction_reg[11:7];
  assign funct3_reg = instruction_reg[14:12];
  assign rs1_reg    = instruction_reg[19:15];
  assign rs2_reg    = instruction_reg[24:20];
  assign funct7_reg = instruction_reg[31:25];

  always_comb begin
    unique case (opcode_reg)
      OpLoad, OpOpImm, OpJalr:
        imm32 = {{20{instruction_reg[31]}}, instruction_reg[31:20]};
      OpStore:
        imm32 = {{20{instruction_reg[31]}}, instruction_reg[31:25], instruction_reg[11:7]};
      OpBranch:
        imm32 = {{20{instruction_reg[31]}}, instruction_reg[7], instruction_reg[30:25],
                 instruction_reg[11:8], 1'b0};
      OpLui, OpAuipc:
        imm32 = {instruction_reg[31:12], 12'b0};
      OpJal:
        imm32 = {{12{instruction_reg[31]}}, instruction_reg[19:12], instruction_reg[20],
                 instruction_reg[30:21], 1'b0};
      default:
        imm32 = '0;
    endcase
  end

  // Signed source, so the size cast sign-extends to XLEN.
  assign Imm_reg = XLEN'(imm32);

  // OP only allows the alternate funct7 encoding on ADD->SUB and SRL->SRA.
  assign op_funct7_ok = (funct7_reg == 7'h00) ||
                        ((funct7_reg == 7'h20) && ((funct3_reg == 3'b000) ||
                                                   (funct3_reg == 3'b101)));

  always_comb begin
    alu_rtype = AluAdd;
    alu_itype = AluAdd;
    unique case (funct3_reg)
      3'b000: begin
        alu_rtype = instruction_reg[30] ? AluSub : AluAdd;
        alu_itype = AluAdd;
      end
      3'b001: begin alu_rtype = AluSll;  alu_itype = AluSll;  end
      3'b010: begin alu_rtype = AluSlt;  alu_itype = AluSlt;  end
      3'b011: begin alu_rtype = AluSltu; alu_itype = AluSltu; end
      3'b100: begin alu_rtype = AluXor;  alu_itype = AluXor;  end
      3'b101: begin
        alu_rtype = instruction_reg[30] ? AluSra : AluSrl;
        alu_itype = instruction_reg[30] ? AluSra : AluSrl;
      end
      3'b110: begin alu_rtype = AluOr;   alu_itype = AluOr;   end
      default: begin alu_rtype = AluAnd; alu_itype = AluAnd;  end
    endcase
  end

  always_comb begin
    unique case (funct3_reg[2:1])
      2'b10:   alu_branch = AluSlt;
      2'b11:   alu_branch = AluSltu;
      default: alu_branch = AluSub;
    endcase
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      StFetch:  if (rdy) state_d = StDecode;
      StDecode: begin
        unique case (opcode_reg)
          OpLoad, OpStore: state_d = StMemAdr;
          OpOp:            state_d = op_funct7_ok ? StExecR : StTrap;
          OpOpImm:         state_d = StExecI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          OpJalr:          state_d = StJalr;
          OpLui:           state_d = StLui;
          OpAuipc:         state_d = StAuipc;
          default:         state_d = StTrap;
        endcase
      end
      StMemAdr: state_d = (opcode_reg == OpStore) ? StMemWr : StMemRd;
      StMemRd:  if (rdy) state_d = StMemWb;
      StMemWr: begin
        if (rdy) begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StExecR, StExecI: state_d = StAluWb;
      StMemWb, StAluWb, StBranch, StJal, StJalr, StLui, StAuipc: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StTrap:   state_d = StTrap;
      default:  state_d = StFetch;
    endcase
  end

  assign illegal_d = illegal_q | (state_d == StTrap);
  assign instret_d = retire ? instret_q + INSTRET_W'(1) : instret_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    IorD_reg       = 1'b0;
    MemWrite_reg   = 1'b0;
    IRWrite_reg    = 1'b0;
    AluSrcA_reg    = 1'b0;
    PCSrc_reg      = 1'b0;
    RegWrite_reg   = 1'b0;
    Branch_reg     = 1'b0;
    PCWrite_reg    = 1'b0;
    MtoR_reg       = 2'd0;
    AluSrcB_reg    = 2'd0;
    AluControl_reg = AluAdd;
    mem_req        = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_req     = 1'b1;
        IRWrite_reg = rdy;
        PCWrite_reg = rdy;
        AluSrcB_reg = 2'd1;
      end
      StMemAdr: begin
        AluSrcA_reg = 1'b1;
        AluSrcB_reg = 2'd2;
      end
      StMemRd: begin
        IorD_reg = 1'b1;
        mem_req  = 1'b1;
      end
      StMemWr: begin
        IorD_reg     = 1'b1;
        mem_req      = 1'b1;
        MemWrite_reg = rdy;
      end
      StMemWb: begin
        MtoR_reg     = 2'd1;
        RegWrite_reg = 1'b1;
      end
      StExecR: begin
        AluSrcA_reg    = 1'b1;
        AluControl_reg = alu_rtype;
      end
      StExecI: begin
        AluSrcA_reg    = 1'b1;
        AluSrcB_reg    = 2'd2;
        AluControl_reg = alu_itype;
      end
      StAluWb: RegWrite_reg = 1'b1;
      StBranch: begin
        Branch_reg     = 1'b1;
        PCSrc_reg      = 1'b1;
        AluSrcA_reg    = 1'b1;
        AluSrcB_reg    = 2'd2;
        AluControl_reg = alu_branch;
      end
      StJal, StJalr: begin
        PCWrite_reg  = 1'b1;
        PCSrc_reg    = 1'b1;
        MtoR_reg     = 2'd2;
        RegWrite_reg = 1'b1;
        AluSrcA_reg  = (state_q == StJalr);
        AluSrcB_reg  = 2'd2;
      end
      StLui: begin
        AluControl_reg = AluPassB;
        AluSrcB_reg    = 2'd2;
        RegWrite_reg   = 1'b1;
      end
      StAuipc: begin
        AluSrcB_reg  = 2'd2;
        RegWrite_reg = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCEn_reg      = PCWrite_reg | (Branch_reg & Cond_Chk_reg);
  assign illegal       = illegal_q;
  assign instret       = instret_q;
  assign current_stage = state_q;
  assign next_stage    = state_d;

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// Directed bench for multicycle_ctrl_unit: default instance plus a no-handshake instance and a
// 4-bit retire-counter instance.
module tb_multicycle_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_a, instr_b, instr_c;
  logic        cond;
  logic        rdy_a, rdy_b;

  logic [6:0]  opc_a, f7_a, opc_b, f7_b, opc_c, f7_c;
  logic [4:0]  rs1_a, rs2_a, rd_a, rs1_b, rs2_b, rd_b, rs1_c, rs2_c, rd_c;
  logic [2:0]  f3_a, f3_b, f3_c;
  logic [31:0] imm_a, imm_b, imm_c;
  logic        iord_a, mw_a, irw_a, asa_a, pcs_a, rw_a, br_a, pcw_a, pce_a, mreq_a, ill_a;
  logic        iord_b, mw_b, irw_b, asa_b, pcs_b, rw_b, br_b, pcw_b, pce_b, mreq_b, ill_b;
  logic        iord_c, mw_c, irw_c, asa_c, pcs_c, rw_c, br_c, pcw_c, pce_c, mreq_c, ill_c;
  logic [1:0]  mtor_a, asb_a, mtor_b, asb_b, mtor_c, asb_c;
  logic [3:0]  aluc_a, aluc_b, aluc_c;
  logic [31:0] ret_a, ret_b;
  logic [3:0]  ret_c;
  logic [4:0]  cur_a, nxt_a, cur_b, nxt_b, cur_c, nxt_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_unit dut (
    .clk(clk), .reset(rst_n), .instruction_reg(instr_a), .Cond_Chk_reg(cond),
    .mem_ready(rdy_a), .opcode_reg(opc_a), .rs1_reg(rs1_a), .rs2_reg(rs2_a), .rd_reg(rd_a),
    .funct3_reg(f3_a), .funct7_reg(f7_a), .Imm_reg(imm_a), .IorD_reg(iord_a),
    .MemWrite_reg(mw_a), .IRWrite_reg(irw_a), .AluSrcA_reg(asa_a), .PCSrc_reg(pcs_a),
    .RegWrite_reg(rw_a), .Branch_reg(br_a), .PCWrite_reg(pcw_a), .PCEn_reg(pce_a),
    .MtoR_reg(mtor_a), .AluSrcB_reg(asb_a), .AluControl_reg(aluc_a), .mem_req(mreq_a),
    .illegal(ill_a), .instret(ret_a), .current_stage(cur_a), .next_stage(nxt_a)
  );

  multicycle_ctrl_unit #(.MEM_HANDSHAKE(1'b0)) dut_nh (
    .clk(clk), .reset(rst_n), .instruction_reg(instr_b), .Cond_Chk_reg(cond),
    .mem_ready(rdy_b), .opcode_reg(opc_b), .rs1_reg(rs1_b), .rs2_reg(rs2_b), .rd_reg(rd_b),
    .funct3_reg(f3_b), .funct7_reg(f7_b), .Imm_reg(imm_b), .IorD_reg(iord_b),
    .MemWrite_reg(mw_b), .IRWrite_reg(irw_b), .AluSrcA_reg(asa_b), .PCSrc_reg(pcs_b),
    .RegWrite_reg(rw_b), .Branch_reg(br_b), .PCWrite_reg(pcw_b), .PCEn_reg(pce_b),
    .MtoR_reg(mtor_b), .AluSrcB_reg(asb_b), .AluControl_reg(aluc_b), .mem_req(mreq_b),
    .illegal(ill_b), .instret(ret_b), .current_stage(cur_b), .next_stage(nxt_b)
  );

  multicycle_ctrl_unit #(.INSTRET_W(4)) dut_w4 (
    .clk(clk), .reset(rst_n), .instruction_reg(instr_c), .Cond_Chk_reg(cond),
    .mem_ready(rdy_a), .opcode_reg(opc_c), .rs1_reg(rs1_c), .rs2_reg(rs2_c), .rd_reg(rd_c),
    .funct3_reg(f3_c), .funct7_reg(f7_c), .Imm_reg(imm_c), .IorD_reg(iord_c),
    .MemWrite_reg(mw_c), .IRWrite_reg(irw_c), .AluSrcA_reg(asa_c), .PCSrc_reg(pcs_c),
    .RegWrite_reg(rw_c), .Branch_reg(br_c), .PCWrite_reg(pcw_c), .PCEn_reg(pce_c),
    .MtoR_reg(mtor_c), .AluSrcB_reg(asb_c), .AluControl_reg(aluc_c), .mem_req(mreq_c),
    .illegal(ill_c), .instret(ret_c), .current_stage(cur_c), .next_stage(nxt_c)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    instr_a = 32'h015a04b3;  // add x9,x20,x21
    instr_b = 32'h00512623;  // sw x5,12(x2)
    instr_c = 32'h123452b7;  // lui x5,0x12345
    cond    = 1'b0;
    rdy_a   = 1'b1;
    rdy_b   = 1'b0;
    #2;

    // Reset state
    chk("rst_stage", cur_a, 0);
    chk("rst_instret", ret_a, 0);
    chk("rst_illegal", ill_a, 0);
    chk("rst_regwrite", rw_a, 0);
    chk("rst_irwrite", irw_a, 1);
    do_reset();

    // 1: add
    chk("add_rd", rd_a, 9);
    chk("add_rs1", rs1_a, 20);
    chk("add_rs2", rs2_a, 21);
    chk("add_f7", f7_a, 0);
    chk("add_opc", opc_a, 7'h33);
    chk("add_s0", cur_a, 0);
    step(); chk("add_s1", cur_a, 1);
    step(); chk("add_s6", cur_a, 6); chk("add_rw6", rw_a, 0);
    chk("add_aluc", aluc_a, 0); chk("add_asb", asb_a, 0); chk("add_asa", asa_a, 1);
    step(); chk("add_s8", cur_a, 8); chk("add_rw8", rw_a, 1); chk("add_mtor", mtor_a, 0);
    chk("add_ret_pre", ret_a, 0);
    step(); chk("add_s0b", cur_a, 0); chk("add_ret", ret_a, 1); chk("add_rw0", rw_a, 0);

    // 2: lw with two MEMRD wait cycles
    instr_a = 32'h00812283;
    do_reset();
    chk("lw_imm", imm_a, 8);
    chk("lw_rd", rd_a, 5);
    step(); chk("lw_s1", cur_a, 1);
    step(); chk("lw_s2", cur_a, 2); chk("lw_asb", asb_a, 2); chk("lw_iord2", iord_a, 0);
    step(); chk("lw_s3a", cur_a, 3); chk("lw_iord3", iord_a, 1); chk("lw_mreq", mreq_a, 1);
    rdy_a = 1'b0;
    step(); chk("lw_s3b", cur_a, 3); chk("lw_ret_wait", ret_a, 0);
    step(); chk("lw_s3c", cur_a, 3);
    rdy_a = 1'b1;
    step(); chk("lw_s4", cur_a, 4); chk("lw_mtor", mtor_a, 1); chk("lw_rw", rw_a, 1);
    chk("lw_ret_pre", ret_a, 0);
    step(); chk("lw_s0", cur_a, 0); chk("lw_ret", ret_a, 1);

    // 3: beq taken then not taken
    instr_a = 32'hfe208ee3;
    cond    = 1'b1;
    do_reset();
    chk("beq_imm", imm_a, 32'hFFFFFFFC);
    step(); step(); chk("beq_s9", cur_a, 9); chk("beq_aluc", aluc_a, 1);
    chk("beq_br", br_a, 1); chk("beq_pcsrc", pcs_a, 1); chk("beq_pcw", pcw_a, 0);
    chk("beq_pce_t", pce_a, 1);
    step(); chk("beq_ret1", ret_a, 1);
    cond = 1'b0;
    step(); step(); chk("beq_s9n", cur_a, 9); chk("beq_pce_n", pce_a, 0);
    step(); chk("beq_ret2", ret_a, 2); chk("beq_s0", cur_a, 0);

    // 4: illegal opcode traps and holds until reset
    instr_a = 32'h0000007F;
    do_reset();
    step(); chk("trap_s1", cur_a, 1); chk("trap_nxt", nxt_a, 31);
    step(); chk("trap_s31", cur_a, 31); chk("trap_ill", ill_a, 1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("trap_hold_s", cur_a, 31);
      chk("trap_hold_ill", ill_a, 1);
      chk("trap_hold_ret", ret_a, 0);
      chk("trap_hold_rw", rw_a, 0);
    end
    rst_n = 1'b0;
    #1;
    chk("trap_clr_s", cur_a, 0);
    chk("trap_clr_ill", ill_a, 0);
    #1;
    rst_n = 1'b1;

    // Reset mid-instruction: no partial retire
    instr_a = 32'h015a04b3;
    do_reset();
    step(); step(); step(); chk("mid_s8", cur_a, 8);
    rst_n = 1'b0;
    #1;
    chk("mid_s0", cur_a, 0); chk("mid_rw", rw_a, 0);
    step(); chk("mid_ret", ret_a, 0); chk("mid_s0b", cur_a, 0);
    rst_n = 1'b1;

    // 5: sw with handshake disabled and mem_ready held low
    do_reset();
    chk("sw_imm", imm_b, 12);
    chk("sw_irw", irw_b, 1);
    step(); chk("sw_s1", cur_b, 1);
    step(); chk("sw_s2", cur_b, 2); chk("sw_mw2", mw_b, 0);
    step(); chk("sw_s5", cur_b, 5); chk("sw_mw5", mw_b, 1); chk("sw_iord", iord_b, 1);
    step(); chk("sw_s0", cur_b, 0); chk("sw_mw0", mw_b, 0); chk("sw_ret", ret_b, 1);

    // 6: 16 back-to-back LUI on a 4-bit counter
    rdy_a = 1'b1;
    do_reset();
    chk("lui_imm", imm_c, 32'h12345000);
    for (int i = 0; i < 16; i++) begin
      step(); step();
      chk("lui_s12", cur_c, 12);
      chk("lui_aluc", aluc_c, 10);
      step();
      chk("lui_ret", ret_c, (i + 1) % 16);
    end
    chk("lui_wrap", ret_c, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
